// File: rtl/and_term_engine_if.sv
// and_term_engine_if: config, input and result handshake bundle for and_term_engine
interface and_term_engine_if #(
  parameter int N_IN = 4,
  parameter int N_TERMS = 6
);
  localparam int IDX_W = N_TERMS > 1 ? $clog2(N_TERMS) : 1;
  logic cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [N_IN-1:0] cfg_mask;
  logic in_valid;
  logic in_ready;
  logic [N_IN-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [N_TERMS-1:0] out_data;
  logic busy;
  modport slave (
    input cfg_we, cfg_idx, cfg_mask, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
  modport master (
    output cfg_we, cfg_idx, cfg_mask, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/and_term_engine.sv
// and_term_engine: serial evaluator of runtime-maskable AND-terms over a captured input vector
module and_term_engine #(
  parameter int N_IN = 4,
  parameter int N_TERMS = 6,
  parameter logic [N_TERMS*N_IN-1:0] RESET_MASKS = 24'hCAEBDF
) (
  input logic clk,
  input logic rst,
  and_term_engine_if.slave bus
);
  localparam int IDX_W = N_TERMS > 1 ? $clog2(N_TERMS) : 1;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic [N_IN-1:0] data_r;
  logic [N_TERMS-1:0] acc;
  logic [N_IN-1:0] masks [N_TERMS];
  logic last, accept, cfg_ok;
  assign accept = state == IDLE && bus.in_valid;
  assign cfg_ok = state == IDLE && bus.cfg_we;
  assign last = idx == IDX_W'(N_TERMS - 1);
  always_comb begin
    state_n = state == IDLE ? (bus.in_valid ? EVAL : IDLE) :
              state == EVAL ? (last ? DONE : EVAL) :
              (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      data_r <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        data_r <= bus.in_data;
        idx <= '0;
        acc <= '0;
      end else if (state == EVAL) begin
        acc[idx] <= &(~masks[idx] | data_r);
        idx <= idx + IDX_W'(1);
      end
    end
  end
  // out-of-range indices match no k, so those writes fall away
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_TERMS; k++)
      if (rst) masks[k] <= RESET_MASKS[k*N_IN +: N_IN];
      else if (cfg_ok && bus.cfg_idx == IDX_W'(k)) masks[k] <= bus.cfg_mask;
  end
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_data = state == DONE ? acc : '0;
endmodule

// File: tb/tb_and_term_engine.sv
// tb_and_term_engine: table vectors, directed corner cases and random traffic against a mask model
module tb_and_term_engine;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  and_term_engine_if #(.N_IN(4), .N_TERMS(6)) bus();
  and_term_engine #(.N_IN(4), .N_TERMS(6), .RESET_MASKS(24'hCAEBDF)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  logic [3:0] m [6];
  typedef struct { logic [3:0] d; logic [5:0] exp; } vec_t;
  vec_t vt [7];
  function automatic logic [5:0] model(input logic [3:0] d);
    logic [5:0] r = '0;
    for (int k = 0; k < 6; k++) r[k] = (d & m[k]) == m[k];
    return r;
  endfunction
  task automatic model_reset;
    m[0] = 4'b1111; m[1] = 4'b1101; m[2] = 4'b1011;
    m[3] = 4'b1110; m[4] = 4'b1010; m[5] = 4'b1100;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [2:0] i, input logic [3:0] msk);
    bus.cfg_we = 1; bus.cfg_idx = i; bus.cfg_mask = msk;
    tick;
    bus.cfg_we = 0;
    if (i < 6) m[i] = msk;
  endtask
  task automatic send(input logic [3:0] d, input int hold, input bit cfg_mid, output logic [5:0] res);
    int lat;
    check("in_ready before accept", bus.in_ready, 1);
    bus.in_valid = 1; bus.in_data = d;
    tick;
    bus.in_valid = 0; bus.cfg_we = 0; bus.in_data = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      check("busy in eval", bus.busy, 1);
      check("out_data zero in eval", bus.out_data, 0);
      if (cfg_mid && lat == 3) begin
        bus.cfg_we = 1; bus.cfg_idx = 3'd5; bus.cfg_mask = 4'b0000;
      end
      tick;
      bus.cfg_we = 0;
      bus.in_data = 4'($urandom);
      lat++;
    end
    check("out_valid latency", lat, 7);
    check("busy in done", bus.busy, 1);
    check("in_ready low in done", bus.in_ready, 0);
    res = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      tick;
      check("held out_data", bus.out_data, res);
      check("held out_valid", bus.out_valid, 1);
      check("held in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1;
    tick;
    bus.out_ready = 0;
    check("in_ready after handshake", bus.in_ready, 1);
    check("out_valid after handshake", bus.out_valid, 0);
    check("out_data zero in idle", bus.out_data, 0);
    check("busy after handshake", bus.busy, 0);
  endtask
  task automatic run(input logic [3:0] d, input int hold, input bit cfg_mid);
    logic [5:0] exp, res;
    exp = model(d);
    send(d, hold, cfg_mid, res);
    check("model result", res, exp);
  endtask
  initial begin
    logic [5:0] res;
    logic [5:0] q [$];
    logic [5:0] e;
    int last_acc, cyc, got;
    bit seen;
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_mask = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    model_reset();
    vt[0] = '{4'b1111, 6'b111111};
    vt[1] = '{4'b1101, 6'b100010};
    vt[2] = '{4'b0000, 6'b000000};
    vt[3] = '{4'b1010, 6'b010000};
    vt[4] = '{4'b0111, 6'b000000};
    vt[5] = '{4'b1110, 6'b111000};
    vt[6] = '{4'b1100, 6'b100000};
    tick; tick;
    check("reset in_ready", bus.in_ready, 1);
    check("reset busy", bus.busy, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 0);
    rst = 0;
    tick;
    for (int i = 0; i < 7; i++) begin
      send(vt[i].d, 0, 0, res);
      check("table result", res, vt[i].exp);
    end
    cfg(3'd0, 4'b0000);
    send(4'b0000, 0, 0, res);
    check("empty mask term", res, 6'b000001);
    cfg(3'd7, 4'b1111);
    send(4'b0000, 0, 0, res);
    check("idx 7 write ignored", res, 6'b000001);
    cfg(3'd0, 4'b1111);
    send(4'b0000, 5, 1, res);
    check("hold with cfg in eval", res, 6'b000000);
    send(4'b0000, 0, 0, res);
    check("cfg in eval dropped", res, 6'b000000);
    bus.cfg_we = 1; bus.cfg_idx = 3'd1; bus.cfg_mask = 4'b0000;
    m[1] = 4'b0000;
    send(4'b0000, 0, 0, res);
    check("cfg with accept", res, 6'b000010);
    bus.in_valid = 1; bus.in_data = 4'b1111;
    tick;
    bus.in_valid = 0;
    tick; tick; tick;
    rst = 1;
    tick;
    rst = 0;
    check("abort in_ready", bus.in_ready, 1);
    check("abort out_valid", bus.out_valid, 0);
    check("abort busy", bus.busy, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus.out_valid) seen = 1;
    end
    check("no result after abort", seen, 0);
    model_reset();
    send(4'b0000, 0, 0, res);
    check("masks restored by reset", res, 6'b000000);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        if ($urandom_range(3, 0) == 0) begin
          bus.cfg_we = 1; bus.cfg_idx = 3'($urandom_range(7, 0)); bus.cfg_mask = 4'($urandom);
          if (bus.cfg_idx < 6) m[bus.cfg_idx] = bus.cfg_mask;
        end else cfg(3'($urandom_range(7, 0)), 4'($urandom));
      end
      run(4'($urandom), $urandom_range(3, 0), 1'($urandom));
    end
    last_acc = -1; cyc = 0; got = 0;
    bus.out_ready = 1; bus.in_valid = 1; bus.in_data = 4'($urandom);
    while (got < 12 && cyc < 400) begin
      if (bus.out_valid) begin
        e = q.size() > 0 ? q.pop_front() : 6'bx;
        check("back-to-back result", bus.out_data, e);
        got++;
      end
      if (bus.in_ready) begin
        q.push_back(model(bus.in_data));
        if (last_acc >= 0) check("accept spacing", cyc - last_acc, 8);
        last_acc = cyc;
      end
      tick;
      cyc++;
      bus.in_data = 4'($urandom);
    end
    check("back-to-back count", got, 12);
    bus.in_valid = 0;
    for (int i = 0; i < 10; i++) tick;
    bus.out_ready = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
